// File: rtl/inst_rom_responder.sv
// Instruction-memory responder for the fetch stage: registered, back-pressurable
// word array with a program-load write port and a branch flush.
module inst_rom_responder #(
    parameter int unsigned DEPTH_LOG2 = 10,
    parameter logic [31:0] NOP_INST   = 32'h00000013
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        reqValidIn,
    output logic        reqReadyOut,
    input  logic [31:0] instAddrIn,
    output logic        respValidOut,
    input  logic        respReadyIn,
    output logic [31:0] instOut,
    output logic [31:0] instAddrOut,
    output logic        instErrOut,
    input  logic        loadEnIn,
    input  logic [31:0] loadAddrIn,
    input  logic [31:0] loadDataIn,
    input  logic        flushIn
);

    localparam int unsigned DEPTH    = 1 << DEPTH_LOG2;
    localparam int unsigned IDX_W    = DEPTH_LOG2;
    localparam int unsigned HI_SHIFT = DEPTH_LOG2 + 2;

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } state_t;

    state_t state_q;
    state_t state_d;

    logic [31:0] mem [DEPTH];

    logic [31:0] inst_q;
    logic [31:0] inst_addr_q;
    logic        inst_err_q;

    logic             accept;
    logic             req_err;
    logic             load_ok;
    logic [IDX_W-1:0] req_idx;
    logic [IDX_W-1:0] load_idx;

    // Load byte-lane bits are intentionally ignored; word writes only.
    logic unused_load_lsbs;
    assign unused_load_lsbs = ^loadAddrIn[1:0];

    assign req_idx  = instAddrIn[DEPTH_LOG2+1:2];
    assign load_idx = loadAddrIn[DEPTH_LOG2+1:2];
    assign req_err  = (instAddrIn[1:0] != 2'b00)
                   || ((instAddrIn >> HI_SHIFT) != 32'd0);
    assign load_ok  = loadEnIn && ((loadAddrIn >> HI_SHIFT) == 32'd0);

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= EMPTY;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state and combinational ready; flush wins over everything but reset.
    always_comb begin
        state_d     = state_q;
        reqReadyOut = 1'b0;
        accept      = 1'b0;

        reqReadyOut = !rst && !loadEnIn && !flushIn
                   && ((state_q == EMPTY) || respReadyIn);
        accept      = reqValidIn && reqReadyOut;

        if (flushIn) begin
            state_d = EMPTY;
        end else if (accept) begin
            state_d = FULL;
        end else if ((state_q == FULL) && respReadyIn) begin
            state_d = EMPTY;
        end
    end

    // Response registers double as the synchronous RAM read register.
    always_ff @(posedge clk) begin
        if (rst) begin
            inst_q      <= NOP_INST;
            inst_addr_q <= 32'd0;
            inst_err_q  <= 1'b0;
        end else if (accept) begin
            inst_addr_q <= instAddrIn;
            inst_err_q  <= req_err;
            if (req_err) begin
                inst_q <= NOP_INST;
            end else begin
                inst_q <= mem[req_idx];
            end
        end
    end

    // Program-load write port; array contents survive reset.
    always_ff @(posedge clk) begin
        if (!rst && load_ok) begin
            mem[load_idx] <= loadDataIn;
        end
    end

    assign respValidOut = (state_q == FULL);
    assign instOut      = inst_q;
    assign instAddrOut  = inst_addr_q;
    assign instErrOut   = inst_err_q;

endmodule

// File: tb/tb_inst_rom_responder.sv
// Directed self-checking bench for inst_rom_responder.
module tb_inst_rom_responder;

    logic        clk = 1'b0;
    logic        rst;
    logic        reqValidIn;
    logic        reqReadyOut;
    logic [31:0] instAddrIn;
    logic        respValidOut;
    logic        respReadyIn;
    logic [31:0] instOut;
    logic [31:0] instAddrOut;
    logic        instErrOut;
    logic        loadEnIn;
    logic [31:0] loadAddrIn;
    logic [31:0] loadDataIn;
    logic        flushIn;

    int n_cmp  = 0;
    int n_fail = 0;

    localparam logic [31:0] NOP = 32'h00000013;

    inst_rom_responder #(.DEPTH_LOG2(10), .NOP_INST(32'h00000013)) dut (
        .clk(clk), .rst(rst),
        .reqValidIn(reqValidIn), .reqReadyOut(reqReadyOut), .instAddrIn(instAddrIn),
        .respValidOut(respValidOut), .respReadyIn(respReadyIn),
        .instOut(instOut), .instAddrOut(instAddrOut), .instErrOut(instErrOut),
        .loadEnIn(loadEnIn), .loadAddrIn(loadAddrIn), .loadDataIn(loadDataIn),
        .flushIn(flushIn)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic load_word(input logic [31:0] a, input logic [31:0] d);
        loadEnIn = 1'b1; loadAddrIn = a; loadDataIn = d;
        step();
        loadEnIn = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; reqValidIn = 1'b1; instAddrIn = 32'h0; respReadyIn = 1'b1;
        loadEnIn = 1'b0; loadAddrIn = 32'h0; loadDataIn = 32'h0; flushIn = 1'b0;
        step(); step();
        n_cmp++; if (respValidOut !== 1'b0) begin n_fail++; $display("FAIL reset_valid got %0b want 0", respValidOut); end
        n_cmp++; if (instOut !== NOP) begin n_fail++; $display("FAIL reset_inst got %h want %h", instOut, NOP); end
        n_cmp++; if (instAddrOut !== 32'h0) begin n_fail++; $display("FAIL reset_addr got %h want 0", instAddrOut); end
        n_cmp++; if (instErrOut !== 1'b0) begin n_fail++; $display("FAIL reset_err got %0b want 0", instErrOut); end
        n_cmp++; if (reqReadyOut !== 1'b0) begin n_fail++; $display("FAIL reset_ready got %0b want 0", reqReadyOut); end
        rst = 1'b0; reqValidIn = 1'b0;
        step();
    endtask

    task automatic test_back_to_back();
        load_word(32'h0, 32'h00500093);
        load_word(32'h4, 32'h00100113);
        reqValidIn = 1'b1; instAddrIn = 32'h0; respReadyIn = 1'b1;
        #1;
        n_cmp++; if (reqReadyOut !== 1'b1) begin n_fail++; $display("FAIL b2b_ready got %0b want 1", reqReadyOut); end
        step();
        n_cmp++; if (respValidOut !== 1'b1) begin n_fail++; $display("FAIL b2b_valid0 got %0b want 1", respValidOut); end
        n_cmp++; if (instOut !== 32'h00500093) begin n_fail++; $display("FAIL b2b_inst0 got %h want 00500093", instOut); end
        n_cmp++; if (instAddrOut !== 32'h0) begin n_fail++; $display("FAIL b2b_addr0 got %h want 0", instAddrOut); end
        n_cmp++; if (instErrOut !== 1'b0) begin n_fail++; $display("FAIL b2b_err0 got %0b want 0", instErrOut); end
        instAddrIn = 32'h4;
        step();
        n_cmp++; if (respValidOut !== 1'b1) begin n_fail++; $display("FAIL b2b_valid1 got %0b want 1", respValidOut); end
        n_cmp++; if (instOut !== 32'h00100113) begin n_fail++; $display("FAIL b2b_inst1 got %h want 00100113", instOut); end
        n_cmp++; if (instAddrOut !== 32'h4) begin n_fail++; $display("FAIL b2b_addr1 got %h want 4", instAddrOut); end
        reqValidIn = 1'b0;
        step();
        n_cmp++; if (respValidOut !== 1'b0) begin n_fail++; $display("FAIL b2b_drain got %0b want 0", respValidOut); end
        n_cmp++; if (instOut !== 32'h00100113) begin n_fail++; $display("FAIL b2b_hold got %h want 00100113", instOut); end
    endtask

    task automatic test_backpressure();
        respReadyIn = 1'b0; reqValidIn = 1'b1; instAddrIn = 32'h0;
        step();
        instAddrIn = 32'h4;
        for (int i = 0; i < 3; i++) begin
            step();
            n_cmp++; if (respValidOut !== 1'b1) begin n_fail++; $display("FAIL bp_valid[%0d] got %0b want 1", i, respValidOut); end
            n_cmp++; if (instOut !== 32'h00500093) begin n_fail++; $display("FAIL bp_inst[%0d] got %h want 00500093", i, instOut); end
            n_cmp++; if (instAddrOut !== 32'h0) begin n_fail++; $display("FAIL bp_addr[%0d] got %h want 0", i, instAddrOut); end
            n_cmp++; if (reqReadyOut !== 1'b0) begin n_fail++; $display("FAIL bp_ready[%0d] got %0b want 0", i, reqReadyOut); end
        end
        respReadyIn = 1'b1;
        #1;
        n_cmp++; if (reqReadyOut !== 1'b1) begin n_fail++; $display("FAIL bp_release_ready got %0b want 1", reqReadyOut); end
        step();
        n_cmp++; if (instOut !== 32'h00100113) begin n_fail++; $display("FAIL bp_next_inst got %h want 00100113", instOut); end
        n_cmp++; if (instAddrOut !== 32'h4) begin n_fail++; $display("FAIL bp_next_addr got %h want 4", instAddrOut); end
        reqValidIn = 1'b0;
        step();
    endtask

    task automatic test_error();
        respReadyIn = 1'b1; reqValidIn = 1'b1; instAddrIn = 32'h2;
        step();
        n_cmp++; if (instOut !== NOP) begin n_fail++; $display("FAIL mis_inst got %h want %h", instOut, NOP); end
        n_cmp++; if (instErrOut !== 1'b1) begin n_fail++; $display("FAIL mis_err got %0b want 1", instErrOut); end
        n_cmp++; if (instAddrOut !== 32'h2) begin n_fail++; $display("FAIL mis_addr got %h want 2", instAddrOut); end
        instAddrIn = 32'h1000;
        step();
        n_cmp++; if (instOut !== NOP) begin n_fail++; $display("FAIL oor_inst got %h want %h", instOut, NOP); end
        n_cmp++; if (instErrOut !== 1'b1) begin n_fail++; $display("FAIL oor_err got %0b want 1", instErrOut); end
        n_cmp++; if (instAddrOut !== 32'h1000) begin n_fail++; $display("FAIL oor_addr got %h want 1000", instAddrOut); end
        instAddrIn = 32'hFFC;
        step();
        n_cmp++; if (instErrOut !== 1'b0) begin n_fail++; $display("FAIL top_word_err got %0b want 0", instErrOut); end
        instAddrIn = 32'h0;
        step();
        n_cmp++; if (instOut !== 32'h00500093) begin n_fail++; $display("FAIL post_err_inst got %h want 00500093", instOut); end
        n_cmp++; if (instErrOut !== 1'b0) begin n_fail++; $display("FAIL post_err_err got %0b want 0", instErrOut); end
        reqValidIn = 1'b0;
        step();
    endtask

    task automatic test_flush();
        respReadyIn = 1'b0; reqValidIn = 1'b1; instAddrIn = 32'h0;
        step();
        instAddrIn = 32'h4; flushIn = 1'b1; respReadyIn = 1'b1;
        #1;
        n_cmp++; if (reqReadyOut !== 1'b0) begin n_fail++; $display("FAIL flush_ready got %0b want 0", reqReadyOut); end
        step();
        flushIn = 1'b0; reqValidIn = 1'b0;
        n_cmp++; if (respValidOut !== 1'b0) begin n_fail++; $display("FAIL flush_valid got %0b want 0", respValidOut); end
        n_cmp++; if (instOut !== 32'h00500093) begin n_fail++; $display("FAIL flush_hold_inst got %h want 00500093", instOut); end
        n_cmp++; if (instAddrOut !== 32'h0) begin n_fail++; $display("FAIL flush_hold_addr got %h want 0", instAddrOut); end
        step();
    endtask

    task automatic test_load();
        respReadyIn = 1'b1; reqValidIn = 1'b1; instAddrIn = 32'h8;
        loadEnIn = 1'b1; loadAddrIn = 32'h8; loadDataIn = 32'h00300193;
        #1;
        n_cmp++; if (reqReadyOut !== 1'b0) begin n_fail++; $display("FAIL load_ready got %0b want 0", reqReadyOut); end
        step();
        loadEnIn = 1'b0;
        n_cmp++; if (respValidOut !== 1'b0) begin n_fail++; $display("FAIL load_noaccept got %0b want 0", respValidOut); end
        step();
        n_cmp++; if (instOut !== 32'h00300193) begin n_fail++; $display("FAIL load_read got %h want 00300193", instOut); end
        n_cmp++; if (instAddrOut !== 32'h8) begin n_fail++; $display("FAIL load_read_addr got %h want 8", instAddrOut); end
        reqValidIn = 1'b0;
        step();
        load_word(32'hE, 32'h11111111);
        load_word(32'h100C, 32'h22222222);
        reqValidIn = 1'b1; instAddrIn = 32'hC;
        step();
        reqValidIn = 1'b0;
        n_cmp++; if (instOut !== 32'h11111111) begin n_fail++; $display("FAIL load_lsb_oor got %h want 11111111", instOut); end
        step();
    endtask

    task automatic test_reset_mid();
        respReadyIn = 1'b0; reqValidIn = 1'b1; instAddrIn = 32'h4;
        step();
        reqValidIn = 1'b0;
        rst = 1'b1; loadEnIn = 1'b1; loadAddrIn = 32'h0; loadDataIn = 32'hFFFFFFFF;
        step();
        rst = 1'b0; loadEnIn = 1'b0;
        n_cmp++; if (respValidOut !== 1'b0) begin n_fail++; $display("FAIL rstmid_valid got %0b want 0", respValidOut); end
        n_cmp++; if (instOut !== NOP) begin n_fail++; $display("FAIL rstmid_inst got %h want %h", instOut, NOP); end
        n_cmp++; if (instAddrOut !== 32'h0) begin n_fail++; $display("FAIL rstmid_addr got %h want 0", instAddrOut); end
        respReadyIn = 1'b1; reqValidIn = 1'b1; instAddrIn = 32'h0;
        step();
        reqValidIn = 1'b0;
        n_cmp++; if (instOut !== 32'h00500093) begin n_fail++; $display("FAIL rstmid_keep0 got %h want 00500093", instOut); end
        reqValidIn = 1'b1; instAddrIn = 32'h8;
        step();
        reqValidIn = 1'b0;
        n_cmp++; if (instOut !== 32'h00300193) begin n_fail++; $display("FAIL rstmid_keep8 got %h want 00300193", instOut); end
        step();
    endtask

    initial begin
        test_reset();
        test_back_to_back();
        test_backpressure();
        test_error();
        test_flush();
        test_load();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
